// File: rtl/anim_sequencer.sv
// anim_sequencer: button-driven animation controller for the seven-segment display.
//
// Each of the N_BTN raw buttons passes through a 2-FF synchroniser and a counter-based
// debouncer. The debounced level rising produces a one-cycle event, and holding the
// button produces further auto-repeat events when REP_EN is set. Events on channels 0-3
// step the animation index (+/-) and a saturating frame period (+/-). A free-running
// frame counter advances the frame index every `period` cycles, wrapping after
// `frame_limit`. All outputs are registered.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   btn_in       raw buttons: [0] animation+, [1] animation-, [2] slower, [3] faster
//   frame_limit  last valid frame index of the current animation
//   btn_db       debounced button levels
//   btn_evt      one-cycle event pulses (press or repeat)
//   animation    current animation index
//   frame        current frame index
//   tick         one-cycle pulse on every frame advance
//   period       current frame period in cycles
module anim_sequencer #(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned DEB_BITS   = 19,
  parameter int unsigned DEB_VAL    = 450_000,
  parameter int unsigned REP_EN     = 1,
  parameter int unsigned REP_BITS   = 24,
  parameter int unsigned REP_DELAY  = 5_000_000,
  parameter int unsigned REP_RATE   = 2_000_000,
  parameter int unsigned ANI_BITS   = 6,
  parameter int unsigned FRAME_BITS = 6,
  parameter int unsigned PER_BITS   = 25,
  parameter int unsigned PER_RESET  = 10_000_000,
  parameter int unsigned PER_MIN    = 1_000_000,
  parameter int unsigned PER_MAX    = 20_000_000,
  parameter int unsigned PER_STEP   = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_BTN-1:0]      btn_in,
  input  logic [FRAME_BITS-1:0] frame_limit,
  output logic [N_BTN-1:0]      btn_db,
  output logic [N_BTN-1:0]      btn_evt,
  output logic [ANI_BITS-1:0]   animation,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  tick,
  output logic [PER_BITS-1:0]   period
);

  localparam int unsigned PerW = PER_BITS + 1;

  localparam logic [DEB_BITS-1:0] DebLast  = DEB_BITS'(DEB_VAL - 1);
  localparam logic [REP_BITS-1:0] RepDelay = REP_BITS'(REP_DELAY);
  localparam logic [REP_BITS-1:0] RepRate  = REP_BITS'(REP_RATE);
  localparam logic [REP_BITS-1:0] RepOne   = REP_BITS'(1);

  // Period arithmetic is one bit wider so +step/-step can never wrap.
  localparam logic [PER_BITS:0]   PerStepW  = PerW'(PER_STEP);
  localparam logic [PER_BITS:0]   PerMinW   = PerW'(PER_MIN);
  localparam logic [PER_BITS:0]   PerMaxW   = PerW'(PER_MAX);
  localparam logic [PER_BITS-1:0] PerMin    = PER_BITS'(PER_MIN);
  localparam logic [PER_BITS-1:0] PerMax    = PER_BITS'(PER_MAX);
  localparam logic [PER_BITS-1:0] PerReset  = PER_BITS'(PER_RESET);

  logic [N_BTN-1:0] db_vec;
  logic [N_BTN-1:0] evt_vec;

  // ---------------------------------------------------------------------------
  // Per-channel synchroniser, debouncer and event / auto-repeat generator
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic                s1_q, s2_q;
    logic                db_q, db_d;
    logic                prev_q;
    logic                evt_q, evt_d;
    logic                armed_q, armed_d;
    logic                fire;
    logic [DEB_BITS-1:0] deb_q, deb_d;
    logic [REP_BITS-1:0] rep_q, rep_d;

    // Counter runs only while the synchronised input disagrees with the accepted level;
    // any agreeing sample restarts it.
    always_comb begin
      db_d  = db_q;
      deb_d = '0;
      if (s2_q != db_q) begin
        if (deb_q == DebLast) begin
          db_d = ~db_q;
        end else begin
          deb_d = deb_q + DEB_BITS'(1);
        end
      end
    end

    // armed_q marks that the initial delay has elapsed; afterwards the counter reloads
    // to 1 so the next match on RepRate is exactly REP_RATE cycles later.
    always_comb begin
      rep_d   = '0;
      armed_d = 1'b0;
      fire    = 1'b0;
      if ((REP_EN != 0) && db_q) begin
        if (rep_q == (armed_q ? RepRate : RepDelay)) begin
          fire    = 1'b1;
          rep_d   = RepOne;
          armed_d = 1'b1;
        end else begin
          rep_d   = rep_q + RepOne;
          armed_d = armed_q;
        end
      end
      evt_d = (db_q & ~prev_q) | fire;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        db_q    <= 1'b0;
        prev_q  <= 1'b0;
        evt_q   <= 1'b0;
        armed_q <= 1'b0;
        deb_q   <= '0;
        rep_q   <= '0;
      end else begin
        s1_q    <= btn_in[i];
        s2_q    <= s1_q;
        db_q    <= db_d;
        prev_q  <= db_q;
        evt_q   <= evt_d;
        armed_q <= armed_d;
        deb_q   <= deb_d;
        rep_q   <= rep_d;
      end
    end

    assign db_vec[i]  = db_q;
    assign evt_vec[i] = evt_q;
  end

  // ---------------------------------------------------------------------------
  // Animation index, frame period and frame counter
  // ---------------------------------------------------------------------------
  logic [ANI_BITS-1:0]   ani_q, ani_d;
  logic                  ani_chg;
  logic [PER_BITS-1:0]   per_q, per_d;
  logic [PER_BITS:0]     per_w, per_up;
  logic [PER_BITS-1:0]   cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  tick_q, tick_d;

  always_comb begin
    ani_d   = ani_q;
    ani_chg = 1'b0;
    if (evt_vec[0] && !evt_vec[1]) begin
      ani_d   = ani_q + ANI_BITS'(1);
      ani_chg = 1'b1;
    end else if (evt_vec[1] && !evt_vec[0]) begin
      ani_d   = ani_q - ANI_BITS'(1);
      ani_chg = 1'b1;
    end
  end

  always_comb begin
    per_w  = {1'b0, per_q};
    per_up = per_w + PerStepW;
    per_d  = per_q;
    if (evt_vec[2] && !evt_vec[3]) begin
      per_d = (per_up > PerMaxW) ? PerMax : per_up[PER_BITS-1:0];
    end else if (evt_vec[3] && !evt_vec[2]) begin
      per_d = (per_w < PerMinW + PerStepW) ? PerMin : PER_BITS'(per_w - PerStepW);
    end
  end

  // The >= test (rather than ==) lets a shortened period take effect at once even when
  // the count is already past the new limit.
  always_comb begin
    cnt_d   = cnt_q + PER_BITS'(1);
    tick_d  = 1'b0;
    frame_d = frame_q;
    if (ani_chg) begin
      cnt_d   = '0;
      frame_d = '0;
    end else if ({1'b0, cnt_q} + PerW'(1) >= per_w) begin
      cnt_d   = '0;
      tick_d  = 1'b1;
      frame_d = (frame_q >= frame_limit) ? '0 : frame_q + FRAME_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ani_q   <= '0;
      per_q   <= PerReset;
      cnt_q   <= '0;
      frame_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      ani_q   <= ani_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
    end
  end

  assign btn_db    = db_vec;
  assign btn_evt   = evt_vec;
  assign animation = ani_q;
  assign frame     = frame_q;
  assign tick      = tick_q;
  assign period    = per_q;

endmodule

// File: doc/anim_sequencer.md
# anim_sequencer

Parametrised animation controller for the seven-segment display. It debounces an N-channel button bank and turns each press into a single-cycle event, with optional auto-repeat while a button is held. Those events step an animation index and a saturating frame period, and a frame counter advances a frame index with a per-animation wrap limit. It sits between the `ui_in` buttons and the segment decoder and replaces the fixed 4-button logic in the top level.

## Interface

Parameters:
- `N_BTN`, 4: number of button channels (minimum 4; channels 0–3 have fixed functions, channels 4 and above are debounce-only).
- `DEB_BITS`, 19: debounce counter width.
- `DEB_VAL`, 450_000: stable-sample cycles required to accept a level change.
- `REP_EN`, 1: 1 enables auto-repeat.
- `REP_BITS`, 24: repeat counter width.
- `REP_DELAY`, 5_000_000: held cycles before the first repeat event.
- `REP_RATE`, 2_000_000: cycles between subsequent repeat events.
- `ANI_BITS`, 6: animation index width.
- `FRAME_BITS`, 6: frame index width.
- `PER_BITS`, 25: frame-period width.
- `PER_RESET`, 10_000_000: period after reset.
- `PER_MIN`, 1_000_000: lower period bound.
- `PER_MAX`, 20_000_000: upper period bound.
- `PER_STEP`, 1_000_000: period increment/decrement.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `btn_in`  in  N_BTN  raw buttons. [0] animation+, [1] animation−, [2] slower (period+), [3] faster (period−).
- `frame_limit`  in  FRAME_BITS  last valid frame of the current animation.
- `btn_db`  out  N_BTN  debounced levels.
- `btn_evt`  out  N_BTN  one-cycle event pulses (press or repeat).
- `animation`  out  ANI_BITS  current animation index.
- `frame`  out  FRAME_BITS  current frame index.
- `tick`  out  1  one-cycle pulse on each frame advance.
- `period`  out  PER_BITS  current frame period.

## Operation

- All outputs are registered. Reset values:
  - `btn_db`, `btn_evt`, `animation`, `frame`, `tick`: 0.
  - `period`: `PER_RESET`.
  - All internal counters and synchronisers: 0.
- Per channel: a 2-FF synchroniser feeds the debounce logic.
  - While the synchronised value ≠ `btn_db[i]`, the debounce counter increments. When the counter reaches `DEB_VAL−1` with the mismatch still present, `btn_db[i]` toggles and the counter clears.
  - Any cycle with a match clears the counter, so a glitch restarts the count.
- Events:
  - `btn_evt[i]` pulses for one cycle on each 0→1 of `btn_db[i]`.
  - If `REP_EN`=1 and `btn_db[i]` stays 1, the repeat counter first fires after `REP_DELAY` cycles, then every `REP_RATE` cycles.
  - The repeat counter clears when `btn_db[i]`=0. Release produces no event.
- Animation:
  - evt[0] alone: `animation`+1, wrapping all-ones→0.
  - evt[1] alone: `animation`−1, wrapping 0→all-ones.
  - evt[0] and evt[1] together: no change.
  - Any animation change clears `frame` and the frame counter on the same edge; `tick` stays 0.
- Period:
  - evt[2] alone: `period`+`PER_STEP`, saturating at `PER_MAX`.
  - evt[3] alone: `period`−`PER_STEP`, saturating at `PER_MIN`.
  - Both together: no change.
  - Arithmetic is done at PER_BITS+1 width, so no overflow or underflow is possible.
  - A period change does not clear the frame counter.
- Frame counter:
  - Counts 0.. upward each cycle.
  - When count ≥ `period`−1, it clears, `tick`=1 for one cycle, and `frame` advances.
  - Because the test is ≥, a period decrease below the current count causes an advance on the next edge.
  - `frame` advances as: if `frame` ≥ `frame_limit` then 0, else `frame`+1. A limit lowered below the current frame therefore wraps on the next tick.

## Timing

- Raw button change to `btn_db`: 2 sync cycles + `DEB_VAL` cycles.
- `btn_db` rise to `btn_evt`: 1 cycle.
- `btn_evt` to `animation`/`period` update: 1 cycle.
- With the period constant, `tick` pulses every `period` cycles. The first tick after reset occurs at cycle `PER_RESET`.
- Reset asserted mid-operation clears everything immediately, independent of `clk`. A button still held at release of reset must complete a full debounce before `btn_db` rises.

## Test plan

All scenarios use overrides `DEB_VAL`=4, `REP_DELAY`=20, `REP_RATE`=8, `PER_RESET`=10, `PER_MIN`=4, `PER_MAX`=16, `PER_STEP`=4, `frame_limit`=3.

- Reset, no buttons → `tick` every 10 cycles; `frame` sequence 0,1,2,3,0; `period`=10; `animation`=0.
- Bounce: `btn_in[0]` toggled with 3-cycle high pulses, then held 10 cycles → exactly one `btn_evt[0]`; `animation`=1; `frame`=0 on the same edge.
- Hold `btn_in[1]` for 60 cycles from `animation`=0 → events at press, press+20, press+28, press+36, …; `animation` goes 63, 62, 61, …. With `REP_EN`=0 → a single event only.
- Press [2] three times → `period` 14, 16, 16 (saturates). Press [3] five times → 12, 8, 4, 4, 4. Press [2] and [3] simultaneously → `period` unchanged.
- `period`=16 with count at 10, then press [3] → `period`=12, no tick. Press again → `period`=8, tick on the next edge with count cleared.
- Assert reset mid-hold with `animation`=5 and `period`=8 → all outputs return to their reset values immediately. Button still held at release → one event after 2+4 cycles plus 1.
